fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage. Drives the byte address into the synchronous instruction ROM (1-cycle read latency) and absorbs that latency. Buffers returned instructions in a small queue and hands {pc, instr} to decode with a valid/ready handshake. Accepts branch/jump redirects from execute, which flush all wrong-path work.

Parameters:
- P_RESET_PC, 32'h0000_0000: first fetch address after reset.
- P_DEPTH, 2: fetch-queue entries; power of two, ≥2.

Ports:
- i_clk, in, 1: clock; all state updates on the rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- o_imem_addr, out, 32: byte address to the instruction ROM; data returns on the next cycle.
- i_imem_data, in, 32: registered ROM output for the address issued last cycle.
- i_redirect_valid, in, 1: redirect request from execute.
- i_redirect_pc, in, 32: redirect target.
- i_ready, in, 1: decode accepts the queue head this cycle.
- o_valid, out, 1: queue head valid.
- o_pc, out, 32: PC of the head entry.
- o_instr, out, 32: instruction of the head entry.
- o_misaligned, out, 1: head PC has pc[1:0] != 0.

Behaviour:
- State registers:
  - fetch_pc_q: next sequential address.
  - rsp_valid_q / rsp_pc_q: an issue was made last cycle, so i_imem_data is meaningful this cycle.
  - Queue: entries plus count_q.
- Reset (async, while i_reset=1): fetch_pc_q=P_RESET_PC, rsp_valid_q=0, count_q=0, o_valid=0, o_pc=0, o_instr=32'h0000_0013, o_misaligned=0, o_imem_addr=P_RESET_PC. Reset asserted mid-stream discards all in-flight and queued work.
- Per-cycle signals:
  - pop = o_valid & i_ready.
  - push = rsp_valid_q & ~i_redirect_valid.
  - issue = i_redirect_valid | ((count_q + push - pop) < P_DEPTH).
- Address mux:
  - If i_redirect_valid: o_imem_addr = i_redirect_pc.
  - Else: o_imem_addr = fetch_pc_q.
  - The address is combinational from registers and redirect inputs only; there is no path from i_ready to o_imem_addr other than through the issue qualifier.
- Updates on issue:
  - fetch_pc_q <= o_imem_addr + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - rsp_valid_q <= 1; rsp_pc_q <= o_imem_addr.
  - When not issuing: rsp_valid_q <= 0 and fetch_pc_q holds. The ROM data next cycle is ignored.
- Queue push: entry = {rsp_pc_q, i_imem_data, rsp_pc_q[1:0]!=0}, written at the tail.
- Outputs are driven from the queue head only. There is no bypass from i_imem_data to o_instr, so the decode input path is register-only.
- Empty queue: o_valid=0, and o_instr/o_pc hold their last values (don't-care).
- Latency: reset release at cycle 0 issues P_RESET_PC. Data returns at cycle 1 and is pushed. o_valid=1 at cycle 2.
- Steady-state throughput: 1 instr/cycle while i_ready=1.
- Full/backpressure: the issue rule guarantees the response from any issue always has a free slot. The queue never overflows and no response is dropped except by redirect.
- Simultaneous push and pop: count is unchanged and head advances. Push-only increments count; pop-only decrements it.
- Redirect, cycle t:
  - Queue cleared (count_q<=0); o_valid forced 0 in cycle t, so no pop is accepted.
  - The in-flight response is dropped.
  - i_redirect_pc is issued immediately.
  - The target instruction appears on o_valid at cycle t+2.
  - Back-to-back redirects: the last one wins.
- Misaligned redirect target: fetched anyway, with the ROM ignoring addr[1:0]. Sequential PCs keep the low bits, and every resulting entry has o_misaligned=1. Execute raises the exception.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr; logic misaligned;}
  - constant NOP_INSTR = 32'h0000_0013.
  - constant DEFAULT_RESET_PC.
- Sub-module fetch_queue: parameterised FIFO of fetch_entry_t with push/pop/flush, count, and head outputs, using async reset.
- fetch_unit owns PC, issue, and redirect logic only.

Test Plan:
- Reset then i_ready=1, ROM word[n]=n+1 → o_valid first high 2 cycles after reset release. Sequence is pc 0x0,0x4,0x8… with instr 1,2,3…, one per cycle, no gaps.
- Hold i_ready=0 for 5 cycles mid-stream, then release → o_valid stays 1 with a stable head. Issue stops once count=P_DEPTH. On release the sequence resumes with no PC skipped or duplicated.
- Redirect to 0x100 while queue is full and a response is in flight → o_valid=0 that cycle. Next valid output is pc 0x100 two cycles later; no stale PCs appear.
- Redirect asserted in the same cycle i_ready=1 with o_valid=1 → no handshake is counted. Output resumes at the target.
- Redirect to 0x102 → o_pc=0x102, 0x106…, each with o_misaligned=1.
- Redirect to 0xFFFF_FFFC → o_pc sequence 0xFFFF_FFFC then 0x0000_0000. Assert i_reset mid-stream → o_valid drops immediately and fetch restarts at P_RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    function automatic fetch_entry_t idle_entry();
        fetch_entry_t e;
        e.pc         = '0;
        e.instr      = NOP_INSTR;
        e.misaligned = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetch entries with push, pop and a whole-queue flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int P_DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_entry,
    output logic [$clog2(P_DEPTH):0] o_count,
    output fetch_entry_t             o_head
);

    localparam int PTR_W = $clog2(P_DEPTH);

    fetch_entry_t             mem_q [P_DEPTH];
    fetch_entry_t             mem_d [P_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [$clog2(P_DEPTH):0] count_q, count_d;

    // Flush only rewinds pointers; stale payload stays as the don't-care head.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= idle_entry();
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, ROM issue with 1-cycle latency, redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC = DEFAULT_RESET_PC,
    parameter int          P_DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_misaligned
);

    logic [31:0]              fetch_pc_q, fetch_pc_d;
    logic [31:0]              rsp_pc_q, rsp_pc_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [$clog2(P_DEPTH):0] count;
    logic                     push, pop, issue;
    fetch_entry_t             push_entry, head;

    assign o_valid     = (count != '0) && !i_redirect_valid;
    assign pop         = o_valid && i_ready;
    assign push        = rsp_valid_q && !i_redirect_valid;
    assign o_imem_addr = i_redirect_valid ? i_redirect_pc : fetch_pc_q;

    // Issue only when the response can be guaranteed a slot next cycle.
    assign issue = i_redirect_valid ||
                   ((32'(count) + 32'(push) - 32'(pop)) < 32'(P_DEPTH));

    always_comb begin
        push_entry.pc         = rsp_pc_q;
        push_entry.instr      = i_imem_data;
        push_entry.misaligned = (rsp_pc_q[1:0] != 2'b00);
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = 1'b0;
        if (issue) begin
            fetch_pc_d  = o_imem_addr + 32'd4;
            rsp_pc_d    = o_imem_addr;
            rsp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_pc_q  <= P_RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    fetch_queue #(
        .P_DEPTH(P_DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_redirect_valid),
        .i_entry (push_entry),
        .o_count (count),
        .o_head  (head)
    );

    assign o_pc         = head.pc;
    assign o_instr      = head.instr;
    assign o_misaligned = head.misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset and streaming sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .P_RESET_PC(32'h0000_0000),
        .P_DEPTH   (2)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .i_redirect_valid(redir),
        .i_redirect_pc   (redir_pc),
        .i_ready         (ready),
        .o_valid         (valid),
        .o_pc            (pc),
        .o_instr         (instr),
        .o_misaligned    (mis)
    );

    // ROM: word n holds n+1, low address bits ignored, one-cycle latency.
    always @(posedge clk) imem_data <= (imem_addr >> 2) + 32'd1;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_mis;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        int          hs;
        logic        seen;

        //            redir rpc           rdy v  pc            instr         mis addr
        vecs[0]  = '{0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h000};
        vecs[1]  = '{0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h004};
        vecs[2]  = '{0, 32'h0,        1, 1, 32'h000,      32'h1,        0, 32'h008};
        vecs[3]  = '{0, 32'h0,        1, 1, 32'h004,      32'h2,        0, 32'h00C};
        vecs[4]  = '{0, 32'h0,        1, 1, 32'h008,      32'h3,        0, 32'h010};
        vecs[5]  = '{0, 32'h0,        1, 1, 32'h00C,      32'h4,        0, 32'h014};
        vecs[6]  = '{0, 32'h0,        0, 1, 32'h010,      32'h5,        0, 32'h018};
        vecs[7]  = '{0, 32'h0,        0, 1, 32'h010,      32'h5,        0, 32'h018};
        vecs[8]  = '{0, 32'h0,        0, 1, 32'h010,      32'h5,        0, 32'h018};
        vecs[9]  = '{0, 32'h0,        0, 1, 32'h010,      32'h5,        0, 32'h018};
        vecs[10] = '{0, 32'h0,        0, 1, 32'h010,      32'h5,        0, 32'h018};
        vecs[11] = '{0, 32'h0,        1, 1, 32'h010,      32'h5,        0, 32'h018};
        vecs[12] = '{0, 32'h0,        1, 1, 32'h014,      32'h6,        0, 32'h01C};
        vecs[13] = '{0, 32'h0,        1, 1, 32'h018,      32'h7,        0, 32'h020};
        vecs[14] = '{0, 32'h0,        1, 1, 32'h01C,      32'h8,        0, 32'h024};
        vecs[15] = '{0, 32'h0,        1, 1, 32'h020,      32'h9,        0, 32'h028};
        vecs[16] = '{1, 32'h100,      1, 0, 32'h0,        32'h0,        0, 32'h100};
        vecs[17] = '{0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h104};
        vecs[18] = '{0, 32'h0,        1, 1, 32'h100,      32'h41,       0, 32'h108};
        vecs[19] = '{0, 32'h0,        1, 1, 32'h104,      32'h42,       0, 32'h10C};
        vecs[20] = '{1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0,        0, 32'hFFFF_FFFC};
        vecs[21] = '{0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h000};
        vecs[22] = '{0, 32'h0,        0, 1, 32'hFFFF_FFFC, 32'h4000_0000, 0, 32'h004};
        vecs[23] = '{0, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'h4000_0000, 0, 32'h004};
        vecs[24] = '{0, 32'h0,        1, 1, 32'h000,      32'h1,        0, 32'h008};
        vecs[25] = '{1, 32'h102,      1, 0, 32'h0,        32'h0,        0, 32'h102};
        vecs[26] = '{0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h106};
        vecs[27] = '{0, 32'h0,        1, 1, 32'h102,      32'h41,       1, 32'h10A};
        vecs[28] = '{0, 32'h0,        1, 1, 32'h106,      32'h42,       1, 32'h10E};
        vecs[29] = '{1, 32'h200,      1, 0, 32'h0,        32'h0,        0, 32'h200};
        vecs[30] = '{1, 32'h300,      1, 0, 32'h0,        32'h0,        0, 32'h300};
        vecs[31] = '{0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h304};
        vecs[32] = '{0, 32'h0,        1, 1, 32'h300,      32'h0C1,      0, 32'h308};
        vecs[33] = '{0, 32'h0,        1, 1, 32'h304,      32'h0C2,      0, 32'h30C};

        // Reset values
        rst = 1'b1; redir = 1'b0; redir_pc = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("reset valid",  32'(valid), 32'd0);
        chk("reset pc",     pc,         32'h0);
        chk("reset instr",  instr,      32'h0000_0013);
        chk("reset mis",    32'(mis),   32'd0);
        chk("reset addr",   imem_addr,  32'h0);

        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            redir = vecs[i].redir; redir_pc = vecs[i].rpc; ready = vecs[i].rdy;
            #3;
            chk($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            chk($sformatf("row%0d addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("row%0d pc", i),    pc,       vecs[i].exp_pc);
                chk($sformatf("row%0d instr", i), instr,    vecs[i].exp_instr);
                chk($sformatf("row%0d mis", i),   32'(mis), 32'(vecs[i].exp_mis));
            end
            @(posedge clk); #1;
        end

        // Reset asserted mid-stream takes effect without a clock edge
        redir = 1'b0; ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst valid", 32'(valid), 32'd0);
        chk("midrst addr",  imem_addr,  32'h0);
        chk("midrst instr", instr,      32'h0000_0013);
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        chk("restart c0 valid", 32'(valid), 32'd0);
        @(posedge clk); #4;
        chk("restart c1 valid", 32'(valid), 32'd0);
        @(posedge clk); #4;
        chk("restart c2 valid", 32'(valid), 32'd1);
        chk("restart c2 pc",    pc,         32'h0);
        chk("restart c2 instr", instr,      32'h1);
        @(posedge clk); #1;

        // Random backpressure: accepted stream must stay gap-free in PC order
        exp_pc = 32'h4;
        hs = 0;
        for (int c = 0; c < 300; c++) begin
            ready = ($urandom_range(3) != 0);
            #3;
            seen = valid && ready;
            if (seen) begin
                chk("stream pc",    pc,       exp_pc);
                chk("stream instr", instr,    (exp_pc >> 2) + 32'd1);
                chk("stream mis",   32'(mis), 32'd0);
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (hs < 150) begin
            n_bad++;
            $display("FAIL stream throughput: got %0d handshakes expected at least 150", hs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
